ft600_tx_arbiter: RTL and testbench

- Round-robin packet arbiter sharing the single byte-wide TX port of the FT600 245-mode bridge between N requester channels.
- Grants whole packets, never interleaving bytes of different channels. Optionally prefixes each packet with a channel-tagged header byte.
- Sits in the FPGA `clk` domain, directly upstream of the bridge's `tx_en`/`tx_in`/`tx_full` interface.

---
 rtl/ft600_tx_arbiter_pkg.sv | 18 +
 rtl/ft600_tx_arbiter_if.sv | 36 +++
 rtl/ft600_rr_pick.sv | 38 +++
 rtl/ft600_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_ft600_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ft600_tx_arbiter_pkg.sv
// Shared definitions for the FT600 TX arbiter and its helpers.
//   - state_e : arbiter FSM encoding (S_IDLE=0, S_HDR=1, S_DATA=2, S_RELEASE=3)
//   - HDR_TAG : upper nibble of the per-packet channel header byte
//   - CH_W    : width of a channel index (supports up to 16 channels)
package ft600_pkg;

  localparam int unsigned CH_W = 4;

  localparam logic [7:0] HDR_TAG = 8'hA0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_DATA    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/ft600_tx_arbiter_if.sv
// Bundle of requester-side and bridge-side signals around the FT600 TX arbiter.
//   req_valid/req_data/req_last : per-channel byte stream from the requesters
//   req_ready                   : per-channel byte accept (at most one bit high)
//   tx_en/tx_in/tx_full         : byte-wide TX port of the FT600 bridge
//   busy/grant_id/trunc         : grant status
// Modports:
//   master : the arbiter (drives req_ready, tx_*, status)
//   slave  : requesters + bridge (drive req_*, tx_full)
interface ft600_tx_arbiter_if
  import ft600_pkg::*;
#(
  parameter int unsigned N_CH = 4
) ();

  logic [N_CH-1:0]   req_valid;
  logic [8*N_CH-1:0] req_data;
  logic [N_CH-1:0]   req_last;
  logic [N_CH-1:0]   req_ready;
  logic              tx_en;
  logic [7:0]        tx_in;
  logic              tx_full;
  logic              busy;
  logic [CH_W-1:0]   grant_id;
  logic              trunc;

  modport master (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, tx_en, tx_in, busy, grant_id, trunc
  );

  modport slave (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, tx_en, tx_in, busy, grant_id, trunc
  );

endinterface

// File: rtl/ft600_rr_pick.sv
// Combinational round-robin picker: scans i_req starting at i_ptr, wrapping
// modulo N_CH, and returns the first set position.
//   i_req   : request vector, one bit per channel
//   i_ptr   : highest-priority channel this round (must be < N_CH)
//   o_found : at least one request is set
//   o_idx   : winning channel index (0 when o_found is low)
module ft600_rr_pick
  import ft600_pkg::*;
#(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_ptr,
  output logic            o_found,
  output logic [CH_W-1:0] o_idx
);

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      logic [CH_W:0] w_tgt;
      // Candidate for priority slot i: (ptr + i) mod N_CH without a divider.
      w_tgt = (CH_W + 1)'(i_ptr) + (CH_W + 1)'(i);
      if (w_tgt >= (CH_W + 1)'(N_CH)) begin
        w_tgt = w_tgt - (CH_W + 1)'(N_CH);
      end
      // Constant-indexed inner loop keeps the request lookup a plain mux.
      for (int j = 0; j < N_CH; j++) begin
        if (!o_found && i_req[j] && (w_tgt == (CH_W + 1)'(j))) begin
          o_found = 1'b1;
          o_idx   = CH_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ft600_tx_arbiter.sv
// Round-robin packet arbiter sharing the FT600 bridge's byte-wide TX port
// between N_CH requester channels. Whole packets are granted; bytes of
// different channels never interleave. Packets longer than MAX_LEN payload
// bytes are cut and the remainder is sent at the channel's next grant.
//
// Optional feature (macro FT_ARB_HDR_EN): each packet is preceded by one
// header byte HDR_TAG | channel. Undefined: payload bytes only.
//
// Ports:
//   clk : system clock, posedge
//   rst : asynchronous active-high reset
//   bus : ft600_tx_arbiter_if.master (requester streams, bridge TX port, status)
module ft600_tx_arbiter
  import ft600_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = 8
) (
  input logic               clk,
  input logic               rst,
  ft600_tx_arbiter_if.master bus
);

  state_e           r_state, w_state_nxt;
  logic [CH_W-1:0]  r_grant, w_grant_nxt;
  logic [CH_W-1:0]  r_rr_ptr, w_rr_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0] w_cnt_inc;

  logic             w_pick_found;
  logic [CH_W-1:0]  w_pick_idx;

  logic             w_valid_g;
  logic [7:0]       w_data_g;
  logic             w_last_g;

  logic             w_tx_en;
  logic [7:0]       w_tx_in;
  logic             w_trunc;
  logic [N_CH-1:0]  w_ready;

  ft600_rr_pick #(
    .N_CH (N_CH)
  ) u_pick (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  // Granted channel's stream, selected by the registered grant.
  always_comb begin
    w_valid_g = 1'b0;
    w_data_g  = '0;
    w_last_g  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_grant == CH_W'(i)) begin
        w_valid_g = bus.req_valid[i];
        w_data_g  = bus.req_data[8*i +: 8];
        w_last_g  = bus.req_last[i];
      end
    end
  end

  // Ready follows only the bridge's full flag so the requester sees the
  // same transfer condition as tx_en.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_ready[i] = (r_state == S_DATA) && (r_grant == CH_W'(i)) && !bus.tx_full;
    end
  end

  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_cnt;
    w_tx_en     = 1'b0;
    w_tx_in     = '0;
    w_trunc     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_grant_nxt = w_pick_idx;
          w_cnt_nxt   = '0;
`ifdef FT_ARB_HDR_EN
          w_state_nxt = S_HDR;
`else
          w_state_nxt = S_DATA;
`endif
        end
      end

`ifdef FT_ARB_HDR_EN
      S_HDR: begin
        w_tx_in = HDR_TAG | {4'b0000, r_grant};
        w_tx_en = !bus.tx_full;
        if (w_tx_en) begin
          w_state_nxt = S_DATA;
        end
      end
`endif

      S_DATA: begin
        w_tx_in = w_data_g;
        w_tx_en = w_valid_g && !bus.tx_full;
        if (w_tx_en) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_last_g) begin
            w_state_nxt = S_RELEASE;
          end else if (w_cnt_inc == LEN_W'(MAX_LEN)) begin
            // Cut here; the requester's remaining bytes wait for a new grant.
            w_trunc     = 1'b1;
            w_state_nxt = S_RELEASE;
          end
        end
      end

      S_RELEASE: begin
        // Served channel drops to lowest priority for the next scan.
        w_rr_nxt    = (r_grant == CH_W'(N_CH - 1)) ? '0 : r_grant + 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.tx_en     = w_tx_en;
  assign bus.tx_in     = w_tx_in;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.grant_id  = r_grant;
  assign bus.trunc     = w_trunc;

endmodule

// File: tb/tb_ft600_tx_arbiter.sv
// Directed testbench for ft600_tx_arbiter (N_CH=4, MAX_LEN=4).
// Expected streams adapt to FT_ARB_HDR_EN (header byte per packet).
module tb_ft600_tx_arbiter;
  import ft600_pkg::*;

  localparam int unsigned NCH  = 4;
  localparam int unsigned MAXL = 4;
`ifdef FT_ARB_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ft600_tx_arbiter_if #(.N_CH(NCH)) bus ();

  ft600_tx_arbiter #(
    .N_CH    (NCH),
    .MAX_LEN (MAXL),
    .LEN_W   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Requester stimulus: per-channel byte lists with read pointers.
  logic [7:0] st_b [NCH][16];
  logic       st_l [NCH][16];
  int         st_n [NCH];
  int         st_rd[NCH];

  // Observed TX stream and expected stream.
  logic [7:0] out_b[64];
  logic [3:0] out_g[64];
  int         n_out;
  int         busy_cyc;
  int         trunc_cyc;
  logic [7:0] exp_b[64];
  logic [3:0] exp_g[64];
  int         exp_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NCH; i++) begin
      st_n[i]  = 0;
      st_rd[i] = 0;
    end
  endtask

  task automatic clear_log();
    n_out     = 0;
    busy_cyc  = 0;
    trunc_cyc = 0;
    exp_n     = 0;
  endtask

  task automatic load(input int ch, input logic [7:0] b, input logic l);
    st_b[ch][st_n[ch]] = b;
    st_l[ch][st_n[ch]] = l;
    st_n[ch]++;
  endtask

  task automatic drive();
    logic [NCH-1:0]   v;
    logic [NCH-1:0]   l;
    logic [8*NCH-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (st_rd[i] < st_n[i]) begin
        v[i]         = 1'b1;
        l[i]         = st_l[i][st_rd[i]];
        d[8*i +: 8]  = st_b[i][st_rd[i]];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  // One clock: sample at negedge, apply accepted pops just after posedge.
  task automatic tick();
    logic [NCH-1:0] acc;
    @(negedge clk);
    acc = bus.req_ready & bus.req_valid;
    if (bus.tx_en && !bus.tx_full) begin
      if (n_out < 64) begin
        out_b[n_out] = bus.tx_in;
        out_g[n_out] = bus.grant_id;
      end
      n_out++;
    end
    busy_cyc  += int'(bus.busy);
    trunc_cyc += int'(bus.trunc);
    check("en_while_full", 32'(bus.tx_en & bus.tx_full), 0);
    check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
    if (bus.tx_full) check("ready_stall", 32'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) if (acc[i]) st_rd[i]++;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic exp_push(input logic [7:0] b, input int g);
    exp_b[exp_n] = b;
    exp_g[exp_n] = 4'(g);
    exp_n++;
  endtask

  task automatic exp_hdr(input int g);
    if (HDR != 0) exp_push(HDR_TAG | 8'(g), g);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 32'(n_out), 32'(exp_n));
    for (int i = 0; i < exp_n && i < n_out && i < 64; i++) begin
      check({tag, "_byte"}, 32'(out_b[i]), 32'(exp_b[i]));
      check({tag, "_gid"}, 32'(out_g[i]), 32'(exp_g[i]));
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.tx_full = 1'b0;
    clear_stim();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
  endtask

  initial begin
    logic [7:0] b;
    rst         = 1'b1;
    bus.tx_full = 1'b0;
    clear_stim();
    clear_log();
    drive();
    #2;
    check("rst_tx_en", 32'(bus.tx_en), 0);
    check("rst_tx_in", 32'(bus.tx_in), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_gid", 32'(bus.grant_id), 0);
    check("rst_trunc", 32'(bus.trunc), 0);
    check("rst_ready", 32'(bus.req_ready), 0);
    do_reset();

    // Single packet on ch2.
    load(2, 8'h11, 1'b0);
    load(2, 8'h22, 1'b0);
    load(2, 8'h33, 1'b1);
    drive();
    run(10);
    exp_hdr(2);
    exp_push(8'h11, 2);
    exp_push(8'h22, 2);
    exp_push(8'h33, 2);
    compare_stream("single");
    check("single_busy", 32'(busy_cyc), 32'(4 + HDR));
    check("single_trunc", 32'(trunc_cyc), 0);

    // Pointer now past ch2: ch3 beats ch0.
    clear_log();
    load(0, 8'h01, 1'b1);
    load(3, 8'h30, 1'b1);
    drive();
    run(12);
    exp_hdr(3);
    exp_push(8'h30, 3);
    exp_hdr(0);
    exp_push(8'h01, 0);
    compare_stream("rrptr");

    // All channels requesting 1-byte packets continuously.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int g = 0; g < NCH; g++) begin
        b = 8'(8'h10 * (g + 1) + k);
        load(g, b, 1'b1);
      end
    end
    drive();
    run(40);
    for (int k = 0; k < 2; k++) begin
      for (int g = 0; g < NCH; g++) begin
        b = 8'(8'h10 * (g + 1) + k);
        exp_hdr(g);
        exp_push(b, g);
      end
    end
    compare_stream("rr");

    // Backpressure mid-packet; last coincides with MAX_LEN.
    do_reset();
    load(1, 8'h51, 1'b0);
    load(1, 8'h52, 1'b0);
    load(1, 8'h53, 1'b0);
    load(1, 8'h54, 1'b1);
    drive();
    for (int c = 0; c < 16; c++) begin
      bus.tx_full = (c >= 2 + HDR) && (c < 7 + HDR);
      tick();
    end
    bus.tx_full = 1'b0;
    exp_hdr(1);
    exp_push(8'h51, 1);
    exp_push(8'h52, 1);
    exp_push(8'h53, 1);
    exp_push(8'h54, 1);
    compare_stream("bp");
    check("bp_trunc", 32'(trunc_cyc), 0);

    // Truncation at MAX_LEN=4 of a 6-byte packet.
    do_reset();
    for (int i = 0; i < 6; i++) load(1, 8'(8'h61 + i), (i == 5));
    drive();
    run(20);
    exp_hdr(1);
    for (int i = 0; i < 4; i++) exp_push(8'(8'h61 + i), 1);
    exp_hdr(1);
    exp_push(8'h65, 1);
    exp_push(8'h66, 1);
    compare_stream("trunc");
    check("trunc_pulses", 32'(trunc_cyc), 1);

    // Asynchronous reset mid-DATA.
    do_reset();
    for (int i = 0; i < 4; i++) load(3, 8'(8'h71 + i), (i == 3));
    drive();
    run(3 + HDR);
    check("arst_pre_len", 32'(n_out), 32'(2 + HDR));
    check("arst_pre_busy", 32'(bus.busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tx_en", 32'(bus.tx_en), 0);
    check("arst_tx_in", 32'(bus.tx_in), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_gid", 32'(bus.grant_id), 0);
    check("arst_ready", 32'(bus.req_ready), 0);
    check("arst_trunc", 32'(bus.trunc), 0);
    clear_log();
    load(0, 8'h5A, 1'b1);
    drive();
    #2;
    rst = 1'b0;
    run(14);
    exp_hdr(0);
    exp_push(8'h5A, 0);
    exp_hdr(3);
    exp_push(8'h73, 3);
    exp_push(8'h74, 3);
    compare_stream("arst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
